axi_chan_slice: RTL
===================

Name: axi_chan_slice

Overview:
Generic single-clock buffering stage for one AXI valid/ready channel. The payload is opaque and packed by the instantiating wrapper. The mode is selected per instance: passthrough, forward register, backward register, full skid, or N-deep FIFO. It replaces ad-hoc valid gating and per-bridge response FIFOs. It is used to break timing paths and absorb response bursts inside AXI interconnect and bridge wrappers.

Parameters:
P_WIDTH, 64, payload width in bits (>=1).
P_MODE, 3, 0=passthrough, 1=forward register, 2=backward register, 3=full skid (2 entries), 4=FIFO.
P_LOG2DEPTH, 4, FIFO depth = 2**P_LOG2DEPTH. Used only when P_MODE=4; legal range 1..8.

Ports:
aclk  input  1  clock; all state on rising edge.
aresetn  input  1  asynchronous active-low reset.
s_data  input  P_WIDTH  upstream payload.
s_valid  input  1  upstream valid.
s_ready  output  1  upstream ready.
m_data  output  P_WIDTH  downstream payload.
m_valid  output  1  downstream valid.
m_ready  input  1  downstream ready.
level  output  P_LOG2DEPTH+1  number of entries held; 0..2**P_LOG2DEPTH in mode 4, 0..2 in mode 3, 0..1 in modes 1/2, constant 0 in mode 0.

Behaviour:
- Reset (aresetn low, asynchronous):
  - m_valid=0, level=0, all occupancy/pointer state cleared.
  - m_data contents are don't-care; the reset value is 0.
  - Registered s_ready (modes 2,3,4) resets to 0 and rises on the first aclk edge after aresetn deasserts, so nothing is accepted during reset recovery.
- Transfer rule: an upstream transfer occurs when s_valid&s_ready at a clock edge; a downstream transfer occurs when m_valid&m_ready.
  - Payload order is preserved and no beat is dropped or duplicated.
  - Once m_valid is asserted, m_valid and m_data stay stable until the transfer completes.
- Mode 0: m_data=s_data, m_valid=s_valid, s_ready=m_ready; purely combinational, zero latency.
- Mode 1: m_valid/m_data are registered.
  - s_ready = ~m_valid | m_ready (combinational).
  - Latency 1 cycle, throughput 1 beat/cycle.
- Mode 2: s_ready is registered, with a single skid register.
  - When the skid register is empty: m_data=s_data, m_valid=s_valid.
  - If m_ready is low while s_valid&s_ready, the beat is captured into the skid register and s_ready drops the next cycle.
  - Latency 0, throughput 1.
- Mode 3: both directions registered, 2 entries (output register + skid register). Latency 1, full throughput.
  - s_ready = (level<2) as a register.
  - A simultaneous push and pop at level=2 is impossible because s_ready=0.
  - A simultaneous push and pop at level=1 keeps level=1.
- Mode 4: circular buffer with wrapping P_LOG2DEPTH-bit read/write pointers and registered output.
  - Latency from push into an empty FIFO to m_valid: 1 cycle.
  - s_ready = registered ~full, where full means level==2**P_LOG2DEPTH. A pop at full raises s_ready the next cycle.
  - A simultaneous push and pop leaves level unchanged, including at level=1; the output must not bubble.
  - Pointer wrap at 2**P_LOG2DEPTH-1 → 0 is exercised every lap.
- level updates the cycle after each transfer: +1 on push only, -1 on pop only, unchanged on both or neither.
- Reset mid-operation: all held beats are discarded and m_valid drops immediately (asynchronously). No partial beat is emitted afterwards.
- Illegal parameter values (P_MODE>4, P_LOG2DEPTH out of range) must stop elaboration via a generate-time error.

Optional Feature:
AXI_SLICE_STATS_EN
- Defined: adds output stall_cnt[31:0] and output peak_level[P_LOG2DEPTH:0].
  - stall_cnt counts cycles with m_valid&~m_ready, saturating at 32'hFFFF_FFFF.
  - peak_level holds the maximum level since reset.
  - Both reset to 0.
- Not defined: these ports and the counters do not exist. Datapath behaviour is identical in both builds.

Test Plan:
- Mode 4, P_LOG2DEPTH=2, m_ready=0, push 6 beats 0x1..0x6 → 0x1..0x4 accepted; s_ready=0 from the cycle after the 4th push; level=4. Then m_ready=1 → output 0x1..0x4 in order, and s_ready returns 1 cycle after the first pop.
- Mode 3, s_valid=1 and m_ready toggling 1/0 every cycle over 100 incrementing beats → all 100 received in order; level never exceeds 2; no duplicates.
- Mode 4, level=1, simultaneous push and pop for 20 cycles → level stays 1, m_valid stays high, pointers wrap ≥4 times, data order correct.
- Mode 1 and mode 2, m_ready held 0 with m_valid=1 for 5 cycles → m_data is unchanged every cycle and m_valid never drops.
- Any mode, assert aresetn=0 with 3 beats held → m_valid=0 and level=0 immediately. After release, s_ready=0 for 1 cycle (modes 2–4) and no stale beat appears.
- With AXI_SLICE_STATS_EN, mode 4, hold m_ready=0 for 7 cycles with m_valid=1 → stall_cnt=7, peak_level equals the highest level reached.

Source files
------------

// File: rtl/axi_chan_slice.sv
// Configurable buffering stage for one AXI valid/ready channel: passthrough, forward/backward register, skid, or FIFO.
// Optional build macro AXI_SLICE_STATS_EN adds stall_cnt and peak_level statistics outputs.
module axi_chan_slice #(
  parameter int unsigned P_WIDTH     = 64,
  parameter int unsigned P_MODE      = 3,
  parameter int unsigned P_LOG2DEPTH = 4
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic [P_WIDTH-1:0]   s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic [P_WIDTH-1:0]   m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [P_LOG2DEPTH:0] level
`ifdef AXI_SLICE_STATS_EN
  ,
  output logic [31:0]          stall_cnt,
  output logic [P_LOG2DEPTH:0] peak_level
`endif
);

  localparam int unsigned LW = P_LOG2DEPTH + 1;

  if (P_WIDTH < 1) begin : g_bad_width
    $error("axi_chan_slice: P_WIDTH must be at least 1");
  end
  if (P_MODE > 4) begin : g_bad_mode
    $error("axi_chan_slice: P_MODE %0d is not a legal mode", P_MODE);
  end
  if (P_MODE == 4 && (P_LOG2DEPTH < 1 || P_LOG2DEPTH > 8)) begin : g_bad_depth
    $error("axi_chan_slice: P_LOG2DEPTH %0d outside 1..8", P_LOG2DEPTH);
  end
  if (P_MODE == 3 && P_LOG2DEPTH < 1) begin : g_bad_level
    $error("axi_chan_slice: level port too narrow for skid mode");
  end

  if (P_MODE == 0) begin : g_pass
    logic unused_clk_rst;
    assign unused_clk_rst = ^{aclk, aresetn};

    assign m_data  = s_data;
    assign m_valid = s_valid;
    assign s_ready = m_ready;
    assign level   = '0;

  end else if (P_MODE == 1) begin : g_fwd
    logic               vld_q;
    logic [P_WIDTH-1:0] dat_q;

    // s_ready means the output slot is empty or empties this cycle.
    assign s_ready = ~vld_q | m_ready;

    always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
        vld_q <= 1'b0;
        dat_q <= '0;
      end else if (s_ready) begin
        vld_q <= s_valid;
        if (s_valid) dat_q <= s_data;
      end
    end

    assign m_valid = vld_q;
    assign m_data  = dat_q;
    assign level   = LW'(vld_q);

  end else if (P_MODE == 2) begin : g_bwd
    logic               rdy_q;
    logic               skid_vld;
    logic [P_WIDTH-1:0] skid_dat;
    logic               capture;

    assign capture = s_valid & rdy_q & ~m_ready;

    always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
        rdy_q    <= 1'b0;
        skid_vld <= 1'b0;
        skid_dat <= '0;
      end else begin
        if (skid_vld) begin
          if (m_ready) skid_vld <= 1'b0;
        end else if (capture) begin
          skid_vld <= 1'b1;
          skid_dat <= s_data;
        end
        rdy_q <= skid_vld ? m_ready : ~capture;
      end
    end

    // Gating with rdy_q keeps a beat from leaking through before it is accepted upstream.
    assign s_ready = rdy_q;
    assign m_valid = skid_vld | (s_valid & rdy_q);
    assign m_data  = skid_vld ? skid_dat : s_data;
    assign level   = LW'(skid_vld);

  end else if (P_MODE == 3) begin : g_skid
    logic               rdy_q;
    logic               out_vld, skd_vld;
    logic [P_WIDTH-1:0] out_dat, skd_dat;
    logic               push, pop;
    logic [1:0]         lvl, lvl_nxt;

    assign push    = s_valid & rdy_q;
    assign pop     = out_vld & m_ready;
    assign lvl     = {1'b0, out_vld} + {1'b0, skd_vld};
    assign lvl_nxt = lvl + {1'b0, push} - {1'b0, pop};

    always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
        rdy_q   <= 1'b0;
        out_vld <= 1'b0;
        skd_vld <= 1'b0;
        out_dat <= '0;
        skd_dat <= '0;
      end else begin
        // The skid entry is always older than the input, so it refills the output first.
        if (!out_vld || pop) begin
          out_vld <= skd_vld | push;
          if (skd_vld) out_dat <= skd_dat;
          else if (push) out_dat <= s_data;
          skd_vld <= skd_vld & push;
          if (skd_vld && push) skd_dat <= s_data;
        end else if (push) begin
          skd_vld <= 1'b1;
          skd_dat <= s_data;
        end
        rdy_q <= (lvl_nxt != 2'd2);
      end
    end

    assign s_ready = rdy_q;
    assign m_valid = out_vld;
    assign m_data  = out_dat;
    assign level   = LW'(lvl);

  end else begin : g_fifo
    localparam int unsigned D = 1 << P_LOG2DEPTH;

    logic [P_WIDTH-1:0]     mem [D];
    logic [P_LOG2DEPTH-1:0] wr_ptr, rd_ptr;
    logic [P_LOG2DEPTH:0]   cnt, cnt_nxt;
    logic                   vld_q, rdy_q;
    logic                   push, pop;

    assign push    = s_valid & rdy_q;
    assign pop     = vld_q & m_ready;
    assign cnt_nxt = cnt + LW'(push) - LW'(pop);

    always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
        vld_q  <= 1'b0;
        rdy_q  <= 1'b0;
        for (int unsigned i = 0; i < D; i++) mem[i] <= '0;
      end else begin
        if (push) begin
          mem[wr_ptr] <= s_data;
          wr_ptr      <= wr_ptr + 1'b1;
        end
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        cnt   <= cnt_nxt;
        vld_q <= (cnt_nxt != '0);
        rdy_q <= (cnt_nxt != LW'(D));
      end
    end

    // Head entry is read straight from storage so a push+pop at level 1 shows the new beat without a bubble.
    assign s_ready = rdy_q;
    assign m_valid = vld_q;
    assign m_data  = mem[rd_ptr];
    assign level   = cnt;
  end

`ifdef AXI_SLICE_STATS_EN
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      stall_cnt  <= '0;
      peak_level <= '0;
    end else begin
      if (m_valid && !m_ready && (stall_cnt != '1)) stall_cnt <= stall_cnt + 32'd1;
      if (level > peak_level) peak_level <= level;
    end
  end
`endif

endmodule
